hybrid_seq_ctrl: RTL and testbench
==================================

// Module: hybrid_seq_ctrl
// PURPOSE
//  Program sequencer for the 9-bit hybrid counter/shift-register datapath. Holds a small
//  step table (mode, direction, optional load value, dwell time) and drives the datapath's
//  reset/load/pause/dir/modo/data_in controls so a full demo runs without switches.
//  Sits between the board switches/buttons and the datapath; datapath samples its inputs
//  through 2-FF synchronisers and rising-edge detectors, so all pulses here are stretched.
// PARAMETERS
//  N_STEPS    8           table depth (power of 2, 2..16); AW = $clog2(N_STEPS)
//  PULSE_CYC  4           cycles each ctl_reset/ctl_load pulse stays high, and low after (>=3)
//  UNIT_CYC   25_000_000  clk cycles per dwell unit (1 s at 25 MHz)
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high; clears FSM, table, counters
//  start       in   1   level; sampled in IDLE only -> begin at step 0
//  abort       in   1   level; any active state -> IDLE next cycle
//  loop_en     in   1   1: after last step restart at step 0; 0: finish
//  num_steps   in   AW+1 active steps (0..N_STEPS); latched on start
//  prog_we     in   1   table write strobe (honoured only in IDLE)
//  prog_addr   in   AW  table index
//  prog_wdata  in   16  {load_en[15], modo[14], dir[13], dwell[12:9], data[8:0]}
//  ctl_reset   out  1   to datapath reset
//  ctl_load    out  1   to datapath load
//  ctl_pause   out  1   to datapath pause
//  ctl_dir     out  1   to datapath dir
//  ctl_modo    out  1   to datapath modo
//  ctl_data    out  9   to datapath data_in
//  busy        out  1   1 in every state except IDLE
//  step_idx    out  AW  index of step executing
//  done        out  1   1-cycle pulse when a non-loop run completes
//  prog_err    out  1   1-cycle pulse on prog_we while busy (write dropped)
// BEHAVIOUR
//  Reset: state=IDLE; table all zero; ctl_reset=0, ctl_load=0, ctl_pause=1, ctl_dir=1,
//   ctl_modo=1, ctl_data=0, busy=0, step_idx=0, done=0, prog_err=0.
//  Table: registered write, visible next cycle; read combinationally at step_idx.
//  States: IDLE -> RST_HI -> RST_LO -> FETCH -> [LD_HI -> LD_LO] -> RUN -> FETCH/IDLE.
//  IDLE: ctl_pause=1. start=1 & num_steps!=0 -> RST_HI, step_idx=0, latch num_steps.
//   start=1 & num_steps==0 -> stay IDLE, done pulses next cycle.
//  RST_HI: ctl_reset=1 for exactly PULSE_CYC cycles; RST_LO: ctl_reset=0 PULSE_CYC cycles.
//  FETCH (1 cycle): ctl_dir/ctl_modo/ctl_data <= entry fields (held through step);
//   load_en=1 -> LD_HI else RUN.
//  LD_HI: ctl_load=1 PULSE_CYC cycles; LD_LO: ctl_load=0 PULSE_CYC cycles; -> RUN.
//  RUN: ctl_pause=0 for (dwell+1)*UNIT_CYC cycles (dwell 0 -> 1 unit, 15 -> 16 units);
//   then ctl_pause=1 same cycle as leaving RUN.
//   Not last step: step_idx+1 -> FETCH. Last (step_idx==num_steps-1): loop_en=1 ->
//   step_idx=0, FETCH (no reset pulse); loop_en=0 -> IDLE, done=1 one cycle.
//  ctl_pause=1 in all states except RUN; ctl_reset/ctl_load never high together.
//  abort (priority over all transitions except reset): next cycle IDLE, ctl_reset=0,
//   ctl_load=0, ctl_pause=1, no done; ctl_dir/modo/data hold last values.
//  start while busy ignored. Dwell counter width $clog2(16*UNIT_CYC); cleared on RUN entry.
//  reset mid-run: same as power-on, table contents lost.
// TESTING (UNIT_CYC=10, PULSE_CYC=4, N_STEPS=8, datapath instantiated with fast tick)
//  1 Write 2 entries {ld=1,modo=1,dir=1,dwell=1,data=0x0A},{ld=0,modo=0,dir=0,dwell=0},
//    num_steps=2, start -> ctl_reset high 4 cyc, ctl_load high 4 cyc with ctl_data=0x0A,
//    RUN 20 cyc then RUN 10 cyc, done single pulse, busy low after; datapath q reflects load.
//  2 Same with loop_en=1 -> step_idx sequence 0,1,0,1...; no done; ctl_reset pulses once.
//  3 abort mid LD_HI -> next cycle IDLE, ctl_load=0, ctl_pause=1, no done.
//  4 num_steps=0, start -> busy stays 0, done pulses once; prog_we while busy -> prog_err
//    pulse, table readback unchanged.
//  5 reset during RUN of step 3 -> all outputs at reset values next cycle, table zeroed.
//  6 start held high throughout run -> single run; restarts only after return to IDLE.

Source files
------------

// File: rtl/hybrid_seq_ctrl.sv
// ============================================================================
// Module      : hybrid_seq_ctrl
// Description : Step-table program sequencer driving the 9-bit hybrid
//               counter/shift-register datapath controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hybrid_seq_ctrl #(
  parameter  int N_STEPS   = 8,
  parameter  int PULSE_CYC = 4,
  parameter  int UNIT_CYC  = 25_000_000,
  localparam int AW        = $clog2(N_STEPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          loop_en,
  input  logic [AW:0]   num_steps,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_wdata,
  output logic          ctl_reset,
  output logic          ctl_load,
  output logic          ctl_pause,
  output logic          ctl_dir,
  output logic          ctl_modo,
  output logic [8:0]    ctl_data,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done,
  output logic          prog_err
);

  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam int DW = $clog2(16 * UNIT_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST_HI = 3'd1,
    S_RST_LO = 3'd2,
    S_FETCH  = 3'd3,
    S_LD_HI  = 3'd4,
    S_LD_LO  = 3'd5,
    S_RUN    = 3'd6
  } state_t;

  state_t        r_state;
  logic [15:0]   r_table [N_STEPS];
  logic [AW-1:0] r_step;
  logic [AW:0]   r_num;
  logic [PW-1:0] r_pcnt;
  logic [DW-1:0] r_dcnt;
  logic [3:0]    r_dwell;
  logic          r_ctl_reset, r_ctl_load, r_ctl_pause, r_ctl_dir, r_ctl_modo;
  logic [8:0]    r_ctl_data;
  logic          r_done, r_prog_err;

  logic [15:0]   w_entry;
  logic [31:0]   w_run_len;
  logic [DW-1:0] w_run_end;
  logic          w_pulse_end;
  logic          w_last;

  assign w_entry     = r_table[r_step];
  assign w_run_len   = (32'(r_dwell) + 32'd1) * 32'(UNIT_CYC);
  assign w_run_end   = DW'(w_run_len - 32'd1);
  assign w_pulse_end = (r_pcnt == PW'(PULSE_CYC - 1));
  assign w_last      = ((AW+1)'(r_step) == r_num - (AW+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < N_STEPS; i++) r_table[i] <= '0;
      r_step      <= '0;
      r_num       <= '0;
      r_pcnt      <= '0;
      r_dcnt      <= '0;
      r_dwell     <= '0;
      r_ctl_reset <= 1'b0;
      r_ctl_load  <= 1'b0;
      r_ctl_pause <= 1'b1;
      r_ctl_dir   <= 1'b1;
      r_ctl_modo  <= 1'b1;
      r_ctl_data  <= '0;
      r_done      <= 1'b0;
      r_prog_err  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_prog_err <= prog_we && (r_state != S_IDLE);
      if (prog_we && (r_state == S_IDLE)) r_table[prog_addr] <= prog_wdata;

      // Abort wins over every sequencing decision; dir/modo/data keep their values.
      if (abort && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_ctl_reset <= 1'b0;
        r_ctl_load  <= 1'b0;
        r_ctl_pause <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ctl_pause <= 1'b1;
            if (start) begin
              if (num_steps != '0) begin
                r_state     <= S_RST_HI;
                r_step      <= '0;
                r_num       <= num_steps;
                r_pcnt      <= '0;
                r_ctl_reset <= 1'b1;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          S_RST_HI: begin
            if (w_pulse_end) begin
              r_state     <= S_RST_LO;
              r_pcnt      <= '0;
              r_ctl_reset <= 1'b0;
            end else begin
              r_pcnt <= r_pcnt + PW'(1);
            end
          end
          S_RST_LO: begin
            if (w_pulse_end) r_state <= S_FETCH;
            else             r_pcnt  <= r_pcnt + PW'(1);
          end
          S_FETCH: begin
            r_ctl_dir  <= w_entry[13];
            r_ctl_modo <= w_entry[14];
            r_ctl_data <= w_entry[8:0];
            r_dwell    <= w_entry[12:9];
            r_pcnt     <= '0;
            r_dcnt     <= '0;
            if (w_entry[15]) begin
              r_state    <= S_LD_HI;
              r_ctl_load <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_ctl_pause <= 1'b0;
            end
          end
          S_LD_HI: begin
            if (w_pulse_end) begin
              r_state    <= S_LD_LO;
              r_pcnt     <= '0;
              r_ctl_load <= 1'b0;
            end else begin
              r_pcnt <= r_pcnt + PW'(1);
            end
          end
          S_LD_LO: begin
            if (w_pulse_end) begin
              r_state     <= S_RUN;
              r_dcnt      <= '0;
              r_ctl_pause <= 1'b0;
            end else begin
              r_pcnt <= r_pcnt + PW'(1);
            end
          end
          S_RUN: begin
            if (r_dcnt == w_run_end) begin
              r_ctl_pause <= 1'b1;
              if (!w_last) begin
                r_step  <= r_step + AW'(1);
                r_state <= S_FETCH;
              end else if (loop_en) begin
                r_step  <= '0;
                r_state <= S_FETCH;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_dcnt <= r_dcnt + DW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ctl_reset = r_ctl_reset;
  assign ctl_load  = r_ctl_load;
  assign ctl_pause = r_ctl_pause;
  assign ctl_dir   = r_ctl_dir;
  assign ctl_modo  = r_ctl_modo;
  assign ctl_data  = r_ctl_data;
  assign busy      = (r_state != S_IDLE);
  assign step_idx  = r_step;
  assign done      = r_done;
  assign prog_err  = r_prog_err;

endmodule

`default_nettype wire

// File: tb/tb_hybrid_seq_ctrl.sv
// ============================================================================
// Module      : tb_hybrid_seq_ctrl
// Description : Directed self-checking bench for hybrid_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hybrid_seq_ctrl;

  localparam int N_STEPS   = 8;
  localparam int PULSE_CYC = 4;
  localparam int UNIT_CYC  = 10;
  localparam int AW        = 3;

  logic          clk = 1'b0;
  logic          reset, start, abort, loop_en, prog_we;
  logic [AW:0]   num_steps;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_wdata;
  logic          ctl_reset, ctl_load, ctl_pause, ctl_dir, ctl_modo;
  logic [8:0]    ctl_data;
  logic          busy, done, prog_err;
  logic [AW-1:0] step_idx;

  int checks   = 0;
  int failures = 0;

  hybrid_seq_ctrl #(
    .N_STEPS  (N_STEPS),
    .PULSE_CYC(PULSE_CYC),
    .UNIT_CYC (UNIT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .loop_en   (loop_en),
    .num_steps (num_steps),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_wdata(prog_wdata),
    .ctl_reset (ctl_reset),
    .ctl_load  (ctl_load),
    .ctl_pause (ctl_pause),
    .ctl_dir   (ctl_dir),
    .ctl_modo  (ctl_modo),
    .ctl_data  (ctl_data),
    .busy      (busy),
    .step_idx  (step_idx),
    .done      (done),
    .prog_err  (prog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ctl_reset;
      1:       return ctl_load;
      2:       return ctl_pause;
      default: return done;
    endcase
  endfunction

  // Wait (bounded) for a level, then count negedges it persists; -1 on timeout.
  task automatic meas(input int sel, input logic lvl, output int w);
    int n;
    n = 0;
    w = -1;
    while (sig(sel) !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel) === lvl) begin
      w = 0;
      while (sig(sel) === lvl && w < 400) begin
        @(negedge clk);
        w++;
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ctl_reset"}, 32'(ctl_reset), 32'd0);
    chk({pfx, "_ctl_load"},  32'(ctl_load),  32'd0);
    chk({pfx, "_ctl_pause"}, 32'(ctl_pause), 32'd1);
    chk({pfx, "_ctl_dir"},   32'(ctl_dir),   32'd1);
    chk({pfx, "_ctl_modo"},  32'(ctl_modo),  32'd1);
    chk({pfx, "_ctl_data"},  32'(ctl_data),  32'd0);
    chk({pfx, "_busy"},      32'(busy),      32'd0);
    chk({pfx, "_step_idx"},  32'(step_idx),  32'd0);
    chk({pfx, "_done"},      32'(done),      32'd0);
    chk({pfx, "_prog_err"},  32'(prog_err),  32'd0);
  endtask

  initial begin
    int w, n, rises, dones, nrun;
    int runs [8];
    logic prev_r, prev_p;

    reset = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; prog_we = 1'b0;
    num_steps = '0; prog_addr = '0; prog_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("por");

    // 1: two-step non-loop run
    wr(3'd0, 16'hE20A);
    wr(3'd1, 16'h0155);
    chk("t1_no_prog_err_idle", 32'(prog_err), 32'd0);
    num_steps = 4'd2;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    meas(0, 1'b1, w); chk("t1_reset_width", 32'(w), 32'd4);
    meas(1, 1'b1, w); chk("t1_load_width", 32'(w), 32'd4);
    chk("t1_load_data", 32'(ctl_data), 32'h00A);
    chk("t1_step0_dir", 32'(ctl_dir), 32'd1);
    meas(2, 1'b0, w); chk("t1_run0_width", 32'(w), 32'd20);
    chk("t1_step_idx1", 32'(step_idx), 32'd1);
    meas(2, 1'b0, w); chk("t1_run1_width", 32'(w), 32'd10);
    chk("t1_step1_data", 32'(ctl_data), 32'h155);
    chk("t1_step1_modo", 32'(ctl_modo), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_done_single", 32'(done), 32'd0);

    // 2: looping run
    loop_en = 1'b1;
    pulse_start();
    rises = 0; dones = 0; nrun = 0; prev_r = 1'b0; prev_p = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (ctl_reset && !prev_r) rises++;
      if (done) dones++;
      if (prev_p && !ctl_pause && nrun < 8) begin
        runs[nrun] = int'(step_idx);
        nrun++;
      end
      prev_r = ctl_reset;
      prev_p = ctl_pause;
      @(negedge clk);
    end
    chk("t2_reset_once", 32'(rises), 32'd1);
    chk("t2_no_done", 32'(dones), 32'd0);
    chk("t2_seq0", 32'(runs[0]), 32'd0);
    chk("t2_seq1", 32'(runs[1]), 32'd1);
    chk("t2_seq2", 32'(runs[2]), 32'd0);
    chk("t2_seq3", 32'(runs[3]), 32'd1);
    chk("t2_still_busy", 32'(busy), 32'd1);
    pulse_abort();
    chk("t2_abort_idle", 32'(busy), 32'd0);
    chk("t2_abort_pause", 32'(ctl_pause), 32'd1);
    loop_en = 1'b0;

    // 3: abort during load pulse
    pulse_start();
    n = 0;
    while (ctl_load !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("t3_load_seen", 32'(ctl_load), 32'd1);
    repeat (2) @(negedge clk);
    pulse_abort();
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_load_low", 32'(ctl_load), 32'd0);
    chk("t3_pause_high", 32'(ctl_pause), 32'd1);
    chk("t3_data_held", 32'(ctl_data), 32'h00A);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("t3_no_done", 32'(dones), 32'd0);

    // 4: empty program, then write attempt while busy
    num_steps = 4'd0;
    pulse_start();
    chk("t4_empty_busy", 32'(busy), 32'd0);
    chk("t4_empty_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t4_empty_done_single", 32'(done), 32'd0);
    num_steps = 4'd2;
    pulse_start();
    wr(3'd0, 16'hFFFF);
    chk("t4_prog_err", 32'(prog_err), 32'd1);
    @(negedge clk);
    chk("t4_prog_err_single", 32'(prog_err), 32'd0);
    meas(1, 1'b1, w); chk("t4_load_width", 32'(w), 32'd4);
    chk("t4_table_unchanged", 32'(ctl_data), 32'h00A);
    pulse_abort();

    // 5: reset during RUN of step 3
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'h2011);
    num_steps = 4'd4;
    pulse_start();
    n = 0;
    while (!(step_idx == 3'd3 && ctl_pause == 1'b0) && n < 1000) begin @(negedge clk); n++; end
    chk("t5_reach_step3", 32'(ctl_data), 32'h011);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("t5");
    num_steps = 4'd1;
    pulse_start();
    meas(2, 1'b0, w); chk("t5_run_width", 32'(w), 32'd10);
    chk("t5_table_zero_data", 32'(ctl_data), 32'd0);
    chk("t5_table_zero_dir", 32'(ctl_dir), 32'd0);
    chk("t5_done", 32'(done), 32'd1);

    // 6: start held high
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    rises = 0; prev_r = 1'b0; n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (ctl_reset && !prev_r) rises++;
      prev_r = ctl_reset;
      @(negedge clk);
      n++;
    end
    chk("t6_single_reset", 32'(rises), 32'd1);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t6_restart_busy", 32'(busy), 32'd1);
    chk("t6_restart_reset", 32'(ctl_reset), 32'd1);
    start = 1'b0;
    pulse_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
